fifo_unpacker: RTL and testbench

- Read-side consumer for sync_fifo (or the read port of async_fifo).
- Drains wide FIFO words and emits them as narrow beats on a valid/ready stream, LSB slice first by default.
- Prefetches through a 2-entry word buffer so a FIFO that stays non-empty gives one beat per cycle with no bubbles.
- Sits between the FIFO read port and narrow downstream consumers such as serializers or the 16-bit datapath.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_unpacker_if.sv | 35 +++
 rtl/unpack_word_buf.sv | 54 +++++
 rtl/fifo_unpacker.sv | 93 +++++++++
 tb/tb_fifo_unpacker.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared widths, ratio helpers and the debug state encoding for the FIFO unpacker.
package fifo_pkg;

  localparam int FIFO_DATA_BIT  = 64;
  localparam int UNPACK_OUT_BIT = 16;

  typedef enum logic [1:0] {
    UNPK_IDLE,
    UNPK_FETCH,
    UNPK_STREAM
  } unpk_state_e;

  function automatic int unpack_ratio(input int in_bit, input int out_bit);
    return in_bit / out_bit;
  endfunction

  function automatic int unpack_cnt_bit(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_unpacker_if.sv
// FIFO read port plus narrow valid/ready output stream; master = unpacker side.
interface fifo_unpacker_if
  import fifo_pkg::*;
#(
  parameter int IN_BIT  = FIFO_DATA_BIT,
  parameter int OUT_BIT = UNPACK_OUT_BIT
);
  logic               ren;
  logic [IN_BIT-1:0]  rdata;
  logic               rempty;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_BIT-1:0] out_data;
  logic               out_last;

  modport master (
    output ren,
    input  rdata,
    input  rempty,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  ren,
    output rdata,
    output rempty,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/unpack_word_buf.sv
// Two-entry register FIFO holding whole FIFO words; head is visible combinationally.
module unpack_word_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DATA_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Words are cleared on reset so the output slice reads zero until the first capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) push_i |-> (occ_q != 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) pop_i |-> (occ_q != 2'd0));

endmodule

// File: rtl/fifo_unpacker.sv
// Drains wide FIFO words into narrow beats with a 2-word prefetch buffer.
// Define FIFO_UNPACK_MSB_FIRST_EN to emit the most significant slice first.
module fifo_unpacker
  import fifo_pkg::*;
#(
  parameter int IN_BIT  = FIFO_DATA_BIT,
  parameter int OUT_BIT = UNPACK_OUT_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_unpacker_if.master        bus,
  output logic                   busy
);

  // IN_BIT must be a multiple of OUT_BIT with at least two beats per word.
  localparam int RATIO   = unpack_ratio(IN_BIT, OUT_BIT);
  localparam int CNT_BIT = unpack_cnt_bit(RATIO);

  logic               run_q;
  logic               inflight_q;
  logic [CNT_BIT-1:0] beat_q;
  logic [CNT_BIT-1:0] beat_d;
  logic [IN_BIT-1:0]  head;
  logic [1:0]         occ;
  logic [2:0]         credit;
  logic               beat_wrap;
  logic               fire;
  logic               pop;
  logic [CNT_BIT-1:0] sel;
  logic [OUT_BIT-1:0] slices [RATIO];
  unpk_state_e        state;

  // Buffered plus in-flight words may never exceed the two buffer slots.
  assign credit  = {1'b0, occ} + {2'b00, inflight_q};
  assign bus.ren = run_q && !bus.rempty && (credit < 3'd2);

  assign beat_wrap     = (beat_q == CNT_BIT'(RATIO - 1));
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_last  = bus.out_valid && beat_wrap;
  assign fire          = bus.out_valid && bus.out_ready;
  assign pop           = fire && beat_wrap;

  always_comb begin
    beat_d = beat_q;
    if (fire) beat_d = beat_wrap ? '0 : beat_q + CNT_BIT'(1);
  end

  // run_q holds off reads until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= bus.ren;
      beat_q     <= beat_d;
    end
  end

  unpack_word_buf #(.WIDTH(IN_BIT)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (bus.rdata),
    .pop_i       (pop),
    .head_o      (head),
    .occ_o       (occ)
  );

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign slices[gi] = head[gi*OUT_BIT +: OUT_BIT];
    end
  endgenerate

`ifdef FIFO_UNPACK_MSB_FIRST_EN
  assign sel = CNT_BIT'(RATIO - 1) - beat_q;
`else
  assign sel = beat_q;
`endif

  assign bus.out_data = slices[sel];

  always_comb begin
    state = UNPK_IDLE;
    if (occ != 2'd0)     state = UNPK_STREAM;
    else if (inflight_q) state = UNPK_FETCH;
  end

  assign busy = (state != UNPK_IDLE);

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker driven by a small behavioural FIFO read port.
module tb_fifo_unpacker;

  logic clk;
  logic rst;
  logic busy;
  int   n_vec;
  int   n_err;
  int   n_rd;
  int   n_ren_empty;
  logic hold_empty;
  logic [63:0] fifo_q [$];

  fifo_unpacker_if #(.IN_BIT(64), .OUT_BIT(16)) bus ();

  fifo_unpacker #(.IN_BIT(64), .OUT_BIT(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read side: one-cycle read latency, empty flag refreshed mid-cycle.
  always @(posedge clk) begin
    if (bus.ren && bus.rempty) n_ren_empty++;
    if (bus.ren && !bus.rempty) begin
      bus.rdata <= fifo_q.pop_front();
      n_rd++;
    end
  end

  always @(negedge clk) bus.rempty = hold_empty || (fifo_q.size() == 0);

  function automatic logic [15:0] beat_of(input logic [63:0] w, input int k);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return w[(3-k)*16 +: 16];
`else
    return w[k*16 +: 16];
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] w;
    logic [63:0] bw [3];
    bit          pat [4];
    int          rd0;
    int          idx;

    n_vec = 0; n_err = 0; n_rd = 0; n_ren_empty = 0;
    rst = 1'b0; hold_empty = 1'b0; bus.out_ready = 1'b0; bus.rdata = '0;
    #1;
    chk("rst_ren",   64'(bus.ren), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_last",  64'(bus.out_last), 64'd0);
    chk("rst_data",  64'(bus.out_data), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    step(); step(); step();
    rst = 1'b1;
    step(); step();

    // Single word, free-running consumer.
    bus.out_ready = 1'b1;
    rd0 = n_rd;
    w = 64'hAAAA_BBBB_CCCC_DDDD;
    fifo_q.push_back(w);
    step();
    chk("t1_latency_valid", 64'(bus.out_valid), 64'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", 64'(bus.out_valid), 64'd1);
      chk("t1_data",  64'(bus.out_data), 64'(beat_of(w, k)));
      chk("t1_last",  64'(bus.out_last), 64'(k == 3));
      step();
    end
    chk("t1_valid_end", 64'(bus.out_valid), 64'd0);
    chk("t1_busy_end",  64'(busy), 64'd0);
    chk("t1_reads",     64'(n_rd - rd0), 64'd1);

    // Sixteen preloaded words, continuous output.
    hold_empty = 1'b1;
    for (int k = 0; k < 16; k++) fifo_q.push_back(64'(k));
    step();
    hold_empty = 1'b0;
    step(); step();
    for (int i = 0; i < 64; i++) begin
      chk("t2_valid", 64'(bus.out_valid), 64'd1);
      chk("t2_data",  64'(bus.out_data), 64'(beat_of(64'(i / 4), i % 4)));
      chk("t2_last",  64'(bus.out_last), 64'((i % 4) == 3));
      step();
    end
    chk("t2_valid_end", 64'(bus.out_valid), 64'd0);
    chk("t2_busy_end",  64'(busy), 64'd0);

    // Backpressure with ready pattern 1,0,0,1.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    bw[0] = 64'h1004_1003_1002_1001;
    bw[1] = 64'h2004_2003_2002_2001;
    bw[2] = 64'h3004_3003_3002_3001;
    for (int k = 0; k < 3; k++) fifo_q.push_back(bw[k]);
    idx = 0;
    for (int c = 0; c < 200 && idx < 12; c++) begin
      bus.out_ready = pat[c % 4];
      if (bus.out_valid) begin
        chk("t3_data", 64'(bus.out_data), 64'(beat_of(bw[idx / 4], idx % 4)));
        chk("t3_last", 64'(bus.out_last), 64'((idx % 4) == 3));
        if (bus.out_ready) idx++;
      end
      step();
    end
    chk("t3_beats", 64'(idx), 64'd12);
    bus.out_ready = 1'b1;
    step();
    chk("t3_busy_end", 64'(busy), 64'd0);

    // FIFO reported empty for 50 cycles while a word waits behind the flag.
    hold_empty = 1'b1;
    w = 64'h5555_6666_7777_8888;
    fifo_q.push_back(w);
    for (int c = 0; c < 50; c++) begin
      step();
      chk("t4_ren_valid_busy", {61'd0, bus.ren, bus.out_valid, busy}, 64'd0);
    end
    hold_empty = 1'b0;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      chk("t4_data", 64'(bus.out_data), 64'(beat_of(w, k)));
      step();
    end

    // Asynchronous reset mid-word, then a fresh word.
    w = 64'hAAAA_BBBB_CCCC_DDDD;
    fifo_q.push_back(w);
    step(); step(); step(); step();
    chk("t5_pre_rst_data", 64'(bus.out_data), 64'(beat_of(w, 2)));
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_rst_last",  64'(bus.out_last), 64'd0);
    chk("t5_rst_data",  64'(bus.out_data), 64'd0);
    chk("t5_rst_busy",  64'(busy), 64'd0);
    chk("t5_rst_ren",   64'(bus.ren), 64'd0);
    step(); step();
    rst = 1'b1;
    w = 64'h1111_2222_3333_4444;
    fifo_q.push_back(w);
    step(); step(); step();
    for (int k = 0; k < 4; k++) begin
      chk("t5_valid", 64'(bus.out_valid), 64'd1);
      chk("t5_data",  64'(bus.out_data), 64'(beat_of(w, k)));
      chk("t5_last",  64'(bus.out_last), 64'(k == 3));
      step();
    end
    chk("t5_busy_end", 64'(busy), 64'd0);
    chk("ren_while_empty", 64'(n_ren_empty), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
